// File: rtl/div_arbiter.sv
// div_arbiter: shares one multi-cycle divider between NREQ requesters.
// Each requester owns an operand slot and a held quotient register. A
// round-robin FSM (IDLE -> ISSUE -> WAIT -> DELIVER) issues one division
// at a time. A zero divisor is answered locally with an all-ones quotient.
// A re-request from the requester in service marks the running division
// stale, so its result is dropped and the new operands are divided instead.
//
// Handshake: the request side and the divider side both use one-cycle pulses
// (req_start_i/req_done_o, div_start_o/div_done_i). There is no back-pressure.
// req_busy_o[i] reports that requester i is waiting or in service. div_done_i
// is only accepted in WAIT.
module div_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_start_i,
  input  logic [NREQ*W-1:0]     req_divident_i,
  input  logic [NREQ*W-1:0]     req_divisor_i,
  output logic [NREQ*2*W-1:0]   req_quotient_o,
  output logic [NREQ-1:0]       req_done_o,
  output logic [NREQ-1:0]       req_busy_o,
  output logic [W-1:0]          div_divident_o,
  output logic [W-1:0]          div_divisor_o,
  output logic                  div_start_o,
  input  logic [2*W-1:0]        div_quotient_i,
  input  logic                  div_done_i,
  output logic [1:0]            state_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NREQ-1:0]      pending_q, pending_d, pending_clr;
  logic                 stale_q, stale_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic                 div_start_q, div_start_d;
  logic [W-1:0]         div_a_q, div_a_d;
  logic [W-1:0]         div_b_q, div_b_d;
  logic [NREQ-1:0]      req_done_q, req_done_d;
  logic [NREQ*2*W-1:0]  req_quotient_q;
  logic [W-1:0]         slot_a_q [NREQ];
  logic [W-1:0]         slot_b_q [NREQ];

  logic                 q_load;
  logic [2*W-1:0]       q_val;
  logic                 found;
  logic [IW-1:0]        pick, cand;
  logic                 restart;

  // A new request from the requester currently in service.
  assign restart = req_start_i[grant_q];

  // Round-robin pick starting just after the last grant, then the FSM.
  always_comb begin
    state_d      = state_q;
    stale_d      = stale_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    div_start_d  = 1'b0;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    req_done_d   = '0;
    pending_clr  = '0;
    q_load       = 1'b0;
    q_val        = div_quotient_i;
    found        = 1'b0;
    pick         = last_grant_q;
    cand         = '0;

    for (int off = 1; off <= NREQ; off++) begin
      cand = IW'((int'(last_grant_q) + off) % NREQ);
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d           = pick;
          last_grant_d      = pick;
          pending_clr[pick] = 1'b1;
          if (slot_b_q[pick] == '0) begin
            // Division by zero never reaches the divider.
            q_load           = 1'b1;
            q_val            = '1;
            req_done_d[pick] = 1'b1;
            state_d          = S_DELIVER;
          end else begin
            div_a_d     = slot_a_q[pick];
            div_b_d     = slot_b_q[pick];
            div_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (restart) stale_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_done_i) begin
          if (stale_q || restart) begin
            stale_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            q_load              = 1'b1;
            req_done_d[grant_q] = 1'b1;
            state_d             = S_DELIVER;
          end
        end else if (restart) begin
          stale_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pending_d = (pending_q & ~pending_clr) | req_start_i;
  end

  // State, slot capture and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pending_q      <= '0;
      stale_q        <= 1'b0;
      last_grant_q   <= IW'(NREQ - 1);
      grant_q        <= '0;
      div_start_q    <= 1'b0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      req_done_q     <= '0;
      req_quotient_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_a_q[i] <= '0;
        slot_b_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      stale_q      <= stale_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      div_start_q  <= div_start_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      req_done_q   <= req_done_d;
      if (q_load) req_quotient_q[int'(grant_d)*2*W +: 2*W] <= q_val;
      for (int i = 0; i < NREQ; i++) begin
        if (req_start_i[i]) begin
          slot_a_q[i] <= req_divident_i[i*W +: W];
          slot_b_q[i] <= req_divisor_i[i*W +: W];
        end
      end
    end
  end

  assign req_quotient_o = req_quotient_q;
  assign req_done_o     = req_done_q;
  assign req_busy_o     = pending_q |
                          ((state_q != S_IDLE) ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_q) : '0);
  assign div_divident_o = div_a_q;
  assign div_divisor_o  = div_b_q;
  assign div_start_o    = div_start_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a behavioural divider
// of programmable latency, a start/done logger and an expected service order.
module tb_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int QW   = 2 * W;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_start_i;
  logic [NREQ*W-1:0]   req_divident_i;
  logic [NREQ*W-1:0]   req_divisor_i;
  logic [NREQ*QW-1:0]  req_quotient_o;
  logic [NREQ-1:0]     req_done_o;
  logic [NREQ-1:0]     req_busy_o;
  logic [W-1:0]        div_divident_o;
  logic [W-1:0]        div_divisor_o;
  logic                div_start_o;
  logic [QW-1:0]       div_quotient_i;
  logic                div_done_i;
  logic [1:0]          state_o;

  div_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_start_i    (req_start_i),
    .req_divident_i (req_divident_i),
    .req_divisor_i  (req_divisor_i),
    .req_quotient_o (req_quotient_o),
    .req_done_o     (req_done_o),
    .req_busy_o     (req_busy_o),
    .div_divident_o (div_divident_o),
    .div_divisor_o  (div_divisor_o),
    .div_start_o    (div_start_o),
    .div_quotient_i (div_quotient_i),
    .div_done_i     (div_done_i),
    .state_o        (state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int lat   = 5;

  int          start_cyc_q[$];
  logic [W-1:0] start_a_q[$];
  logic [W-1:0] start_b_q[$];
  int          done_cyc_q[$];
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [QW-1:0] quo(input int i);
    return req_quotient_o[i*QW +: QW];
  endfunction

  // Monitor: log divider starts and check each req_done against exp_q.
  always @(negedge clk) begin
    if (div_start_o) begin
      start_cyc_q.push_back(cyc);
      start_a_q.push_back(div_divident_o);
      start_b_q.push_back(div_divisor_o);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_done_o[i]) begin
        done_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check_eq("unexpected_done", 64'(i), 64'hFF);
        else                   check_eq("done_order", 64'(i), 64'(exp_q.pop_front()));
      end
    end
  end

  // Behavioural divider: answers each div_start after 'lat' cycles.
  initial begin
    int cnt;
    logic [QW-1:0] res;
    cnt = 0;
    res = '0;
    div_done_i = 1'b0;
    div_quotient_i = '0;
    forever begin
      @(negedge clk);
      div_done_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          div_done_i = 1'b1;
          div_quotient_i = res;
        end
      end
      if (div_start_o) begin
        cnt = lat;
        res = QW'(div_divident_o) / QW'(div_divisor_o);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_divident_i[i*W +: W] = a;
    req_divisor_i[i*W +: W]  = b;
  endtask

  task automatic pulse(input logic [NREQ-1:0] m, output int c);
    req_start_i = m;
    c = cyc;
    @(negedge clk);
    req_start_i = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((req_busy_o != '0 || state_o != 2'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check_eq("settle_timeout", 64'(n), 64'(budget - 1));
    wait_cycles(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    start_cyc_q.delete();
    start_a_q.delete();
    start_b_q.delete();
    done_cyc_q.delete();
  endtask

  // ---------------- directed vectors ----------------
  int a1[4] = '{40, 90, 160, 250};
  int b1[4] = '{2, 3, 4, 5};
  int q1[4] = '{20, 30, 40, 50};
  int a2[4] = '{100, 81, 7, 1000};
  int b2[4] = '{4, 9, 7, 1};
  int q2[4] = '{25, 9, 1, 1000};

  initial begin
    int c0, c1;
    reset          = 1'b1;
    req_start_i    = '0;
    req_divident_i = '0;
    req_divisor_i  = '0;
    wait_cycles(3);
    reset = 1'b0;

    // Reset state
    check_eq("rst_state", 64'(state_o), 64'd0);
    check_eq("rst_done", 64'(req_done_o), 64'd0);
    check_eq("rst_busy", 64'(req_busy_o), 64'd0);
    check_eq("rst_div_start", 64'(div_start_o), 64'd0);
    check_eq("rst_quotient", req_quotient_o[QW-1:0] | req_quotient_o[NREQ*QW-1:QW*(NREQ-1)], 64'd0);

    // Single request 1000/10 with a 5-cycle divider
    lat = 5;
    clear_logs();
    set_ops(1, 32'd1000, 32'd10);
    exp_q.push_back(1);
    pulse(4'b0010, c0);
    wait_idle(100);
    check_eq("single_starts", 64'(start_cyc_q.size()), 64'd1);
    check_eq("single_start_lat", 64'(start_cyc_q[0] - c0), 64'd2);
    check_eq("single_op_a", 64'(start_a_q[0]), 64'd1000);
    check_eq("single_op_b", 64'(start_b_q[0]), 64'd10);
    check_eq("single_dones", 64'(done_cyc_q.size()), 64'd1);
    check_eq("single_done_lat", 64'(done_cyc_q[0] - c0), 64'd8);
    check_eq("single_quo1", quo(1), 64'd100);
    check_eq("single_quo0", quo(0), 64'd0);

    // Contention: two simultaneous bursts after reset
    do_reset();
    for (int burst = 0; burst < 2; burst++) begin
      lat = 3;
      clear_logs();
      for (int k = 0; k < NREQ; k++) begin
        if (burst == 0) set_ops(k, W'(a1[k]), W'(b1[k]));
        else            set_ops(k, W'(a2[k]), W'(b2[k]));
        exp_q.push_back(W'(k));
      end
      pulse(4'b1111, c0);
      wait_idle(200);
      check_eq("burst_starts", 64'(start_cyc_q.size()), 64'd4);
      check_eq("burst_first_start", 64'(start_cyc_q[0] - c0), 64'd2);
      check_eq("burst_gap", 64'(start_cyc_q[1] - done_cyc_q[0]), 64'd2);
      for (int k = 0; k < NREQ; k++) begin
        check_eq("burst_order_a", 64'(start_a_q[k]), (burst == 0) ? 64'(a1[k]) : 64'(a2[k]));
        check_eq("burst_quo", quo(k), (burst == 0) ? 64'(q1[k]) : 64'(q2[k]));
      end
    end

    // Zero divisor
    clear_logs();
    set_ops(2, 32'd77, 32'd0);
    exp_q.push_back(2);
    pulse(4'b0100, c0);
    wait_idle(100);
    check_eq("zero_starts", 64'(start_cyc_q.size()), 64'd0);
    check_eq("zero_dones", 64'(done_cyc_q.size()), 64'd1);
    check_eq("zero_done_lat", 64'(done_cyc_q[0] - c0), 64'd2);
    check_eq("zero_quo2", quo(2), 64'hFFFF_FFFF_FFFF_FFFF);

    // Abort: re-request from requester 3 while its division runs
    lat = 6;
    clear_logs();
    set_ops(3, 32'd500, 32'd5);
    exp_q.push_back(3);
    pulse(4'b1000, c0);
    wait_cycles(2);
    check_eq("abort_in_wait", 64'(state_o), 64'd2);
    set_ops(3, 32'd800, 32'd8);
    pulse(4'b1000, c1);
    wait_cycles(5);
    check_eq("abort_no_done_yet", 64'(done_cyc_q.size()), 64'd0);
    check_eq("abort_quo_held", quo(3), 64'd1000);
    wait_idle(100);
    check_eq("abort_starts", 64'(start_cyc_q.size()), 64'd2);
    check_eq("abort_op_a", 64'(start_a_q[1]), 64'd800);
    check_eq("abort_op_b", 64'(start_b_q[1]), 64'd8);
    check_eq("abort_restart_cyc", 64'(start_cyc_q[1] - c0), 64'd10);
    check_eq("abort_dones", 64'(done_cyc_q.size()), 64'd1);
    check_eq("abort_quo3", quo(3), 64'd100);

    // Overwrite: requester 1 asks twice while requester 0 is served
    lat = 4;
    clear_logs();
    set_ops(0, 32'd60, 32'd6);
    exp_q.push_back(0);
    exp_q.push_back(1);
    pulse(4'b0001, c0);
    set_ops(1, 32'd11, 32'd1);
    pulse(4'b0010, c1);
    set_ops(1, 32'd900, 32'd9);
    pulse(4'b0010, c1);
    wait_idle(100);
    check_eq("ovw_starts", 64'(start_cyc_q.size()), 64'd2);
    check_eq("ovw_op_a", 64'(start_a_q[1]), 64'd900);
    check_eq("ovw_op_b", 64'(start_b_q[1]), 64'd9);
    check_eq("ovw_quo1", quo(1), 64'd100);
    check_eq("ovw_quo0", quo(0), 64'd10);

    // Reset during WAIT, then a late div_done
    lat = 8;
    clear_logs();
    set_ops(2, 32'd64, 32'd4);
    pulse(4'b0100, c0);
    wait_cycles(2);
    check_eq("rstw_in_wait", 64'(state_o), 64'd2);
    do_reset();
    check_eq("rstw_state", 64'(state_o), 64'd0);
    check_eq("rstw_busy", 64'(req_busy_o), 64'd0);
    check_eq("rstw_div_start", 64'(div_start_o), 64'd0);
    check_eq("rstw_div_a", 64'(div_divident_o), 64'd0);
    check_eq("rstw_div_b", 64'(div_divisor_o), 64'd0);
    for (int k = 0; k < NREQ; k++) check_eq("rstw_quo", quo(k), 64'd0);
    wait_cycles(8);
    check_eq("rstw_no_done", 64'(done_cyc_q.size()), 64'd0);
    check_eq("rstw_idle", 64'(state_o), 64'd0);
    set_ops(0, 32'd81, 32'd9);
    exp_q.push_back(0);
    pulse(4'b0001, c0);
    wait_idle(100);
    check_eq("rstw_next_dones", 64'(done_cyc_q.size()), 64'd1);
    check_eq("rstw_next_quo0", quo(0), 64'd9);

    check_eq("exp_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
